// File: rtl/ctr_sched_pkg.sv
// Shared types and helpers for the time-shared counter scheduler.
// Holds the FSM state encoding, default sizing and a one-hot decode helper.
package ctr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;
    localparam int PW_DEF   = 8;
    localparam int OH_W     = 32;

    // Wide one-hot decode; callers truncate to their own requester count.
    function automatic logic [OH_W-1:0] onehot(input int unsigned idx);
        return OH_W'(1) << idx;
    endfunction

endpackage

// File: rtl/ctr_sched_rr_arb.sv
// Combinational round-robin pick: the first set request bit after rr_ptr,
// wrapping modulo NREQ, so the previous owner is considered last.
module ctr_sched_rr_arb
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int IW = $clog2(NREQ);

    // Scanning from the farthest candidate back to the nearest lets the
    // closest requester after rr_ptr overwrite any earlier match.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ctr_sched.sv
// Time-shares one up-counter between NREQ requesters under round-robin
// arbitration; each granted requester runs for (len+1) prescaled ticks.
module ctr_sched
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CW-1:0]      len,
    input  logic [PW-1:0]           prescale,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [CW-1:0]           ctr_value
);

    localparam int IW = $clog2(NREQ);

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          arb_valid;
    logic [IW-1:0] arb_winner;
    logic          tick;
    logic          abort;

    ctr_sched_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            target_q <= '0;
            ctr_q    <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            presc_q  <= presc_d;
        end
    end

    // prescale is compared live; an owner dropping its request wins over a tick.
    assign tick  = (presc_q == prescale);
    assign abort = !req[owner_q];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = RUN;
                    owner_d  = arb_winner;
                    rr_ptr_d = arb_winner;
                    target_d = len[int'(arb_winner)*CW +: CW];
                    ctr_d    = '0;
                    presc_d  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (ctr_q != target_q) begin
                        ctr_d = ctr_q + 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q == RUN) begin
            gnt = NREQ'(onehot(32'(owner_q)));
        end
        if (state_q == DONE) begin
            done = NREQ'(onehot(32'(owner_q)));
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign owner     = owner_q;
    assign ctr_value = ctr_q;

endmodule

// File: tb/tb_ctr_sched.sv
// Scoreboard bench for ctr_sched: stimulus queues expected grant/done/abort
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_ctr_sched;

    typedef enum int {EV_GRANT, EV_DONE, EV_ABORT} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [3:0] vec;
        logic [3:0] ctr;
        int         lat;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [7:0]  prescale;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  owner;
    logic [3:0]  ctr_value;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    logic [3:0] prev_gnt = 4'b0;
    int         lat = 0;
    bit         tracking = 1'b0;

    ctr_sched #(
        .NREQ (4),
        .CW   (4),
        .PW   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .prescale  (prescale),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .ctr_value (ctr_value)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l, input logic [7:0] p);
        req      = r;
        len      = l;
        prescale = p;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic pushExp(input ev_kind_t k, input logic [3:0] v, input logic [3:0] c, input int l);
        ev_t e;
        e.kind = k;
        e.vec  = v;
        e.ctr  = c;
        e.lat  = l;
        exp_q.push_back(e);
    endtask

    task automatic compareEvent(input ev_kind_t k, input logic [3:0] v, input logic [3:0] c, input int l);
        ev_t e;
        bit  bad;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind=%0d vec=%b ctr=%0d lat=%0d, none expected",
                     k, v, c, l);
        end else begin
            e   = exp_q.pop_front();
            bad = (e.kind != k);
            if (!bad && k != EV_ABORT) bad = (e.vec !== v);
            if (!bad && k != EV_GRANT) bad = (e.ctr !== c);
            if (!bad && k == EV_DONE)  bad = (e.lat != l);
            if (bad) begin
                errors++;
                $display("[TB] FAIL event: got kind=%0d vec=%b ctr=%0d lat=%0d expected kind=%0d vec=%b ctr=%0d lat=%0d",
                         k, v, c, l, e.kind, e.vec, e.ctr, e.lat);
            end
        end
    endtask

    task automatic waitDone(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (done != 4'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: done never pulsed within 100 cycles, expected a pulse", name);
        end
    endtask

    task automatic waitCtr(input string name, input logic [3:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (gnt != 4'b0 && ctr_value == v) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: ctr_value=%0d while running, expected to reach %0d", name, ctr_value, v);
        end
    endtask

    // Event monitor plus per-cycle one-hot/exclusivity invariants.
    always @(negedge clk) begin
        if (gnt != 4'b0 && prev_gnt == 4'b0) begin
            tracking = 1'b1;
            lat      = 0;
            compareEvent(EV_GRANT, gnt, ctr_value, 0);
        end else if (tracking) begin
            lat++;
        end
        if (prev_gnt != 4'b0 && gnt == 4'b0) begin
            if (done != 4'b0) compareEvent(EV_DONE, done, ctr_value, lat);
            else              compareEvent(EV_ABORT, 4'b0, ctr_value, lat);
            tracking = 1'b0;
        end
        if ((gnt | done) != 4'b0) begin
            checks++;
            if (!$onehot0(gnt) || !$onehot0(done) || (gnt & done) != 4'b0) begin
                errors++;
                $display("[TB] FAIL onehot: got gnt=%b done=%b, expected at most one bit each and disjoint",
                         gnt, done);
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0, 16'h0, 8'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_owner", 32'(owner), 0);
        checkOutput("rst_ctr", 32'(ctr_value), 0);
        reset = 1'b0;

        // T1: single requester, len 3, no prescale
        pushExp(EV_GRANT, 4'b0001, 4'd0, 0);
        pushExp(EV_DONE,  4'b0001, 4'd3, 4);
        applyStimulus(4'b0001, 16'h0003, 8'd0);
        @(negedge clk);
        checkOutput("t1_gnt", 32'(gnt), 1);
        checkOutput("t1_ctr0", 32'(ctr_value), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_ctr%0d", i), 32'(ctr_value), i);
        end
        @(negedge clk);
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_busy_done", 32'(busy), 1);
        checkOutput("t1_gnt_done", 32'(gnt), 0);
        applyStimulus(4'b0, 16'h0, 8'd0);
        @(negedge clk);
        checkOutput("t1_busy_idle", 32'(busy), 0);
        checkOutput("t1_done_idle", 32'(done), 0);

        // T2: all four requesting with len 0 from a fresh pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pushExp(EV_GRANT, 4'(1 << (k % 4)), 4'd0, 0);
            pushExp(EV_DONE,  4'(1 << (k % 4)), 4'd0, 1);
        end
        applyStimulus(4'b1111, 16'h0000, 8'd0);
        for (int k = 0; k < 5; k++) begin
            waitDone("t2_done");
            checkOutput($sformatf("t2_owner%0d", k), 32'(owner), k % 4);
        end
        applyStimulus(4'b0, 16'h0, 8'd0);

        // T3: prescale 2 stretches each tick to three cycles
        pushExp(EV_GRANT, 4'b0100, 4'd0, 0);
        pushExp(EV_DONE,  4'b0100, 4'd1, 6);
        applyStimulus(4'b0100, 16'h0100, 8'd2);
        waitDone("t3_done");
        checkOutput("t3_owner", 32'(owner), 2);
        applyStimulus(4'b0, 16'h0, 8'd0);

        // T4: abort at ctr 4, then round-robin resumes after requester 1
        pushExp(EV_GRANT, 4'b0010, 4'd0, 0);
        pushExp(EV_ABORT, 4'b0000, 4'd4, 0);
        applyStimulus(4'b0010, 16'h0090, 8'd0);
        waitCtr("t4_ctr", 4'd4);
        applyStimulus(4'b0, 16'h0090, 8'd0);
        @(negedge clk);
        checkOutput("t4_gnt", 32'(gnt), 0);
        checkOutput("t4_done", 32'(done), 0);
        checkOutput("t4_ctr_hold", 32'(ctr_value), 4);
        checkOutput("t4_busy", 32'(busy), 0);
        pushExp(EV_GRANT, 4'b0001, 4'd0, 0);
        pushExp(EV_DONE,  4'b0001, 4'd0, 1);
        applyStimulus(4'b0011, 16'h0000, 8'd0);
        waitDone("t4_done_next");
        checkOutput("t4_owner_next", 32'(owner), 0);
        applyStimulus(4'b0, 16'h0, 8'd0);

        // T5: reset while running at ctr 5
        pushExp(EV_GRANT, 4'b0001, 4'd0, 0);
        pushExp(EV_ABORT, 4'b0000, 4'd0, 0);
        applyStimulus(4'b0001, 16'h0009, 8'd0);
        waitCtr("t5_ctr", 4'd5);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_gnt", 32'(gnt), 0);
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_owner", 32'(owner), 0);
        checkOutput("t5_ctr", 32'(ctr_value), 0);
        reset = 1'b0;
        pushExp(EV_GRANT, 4'b0001, 4'd0, 0);
        pushExp(EV_DONE,  4'b0001, 4'd0, 1);
        applyStimulus(4'b1001, 16'h0000, 8'd0);
        waitDone("t5_done");
        checkOutput("t5_owner_next", 32'(owner), 0);
        applyStimulus(4'b0, 16'h0, 8'd0);

        // T6: full-range length reaches all-ones without wrapping
        pushExp(EV_GRANT, 4'b0001, 4'd0, 0);
        pushExp(EV_DONE,  4'b0001, 4'd15, 16);
        applyStimulus(4'b0001, 16'h000F, 8'd0);
        waitDone("t6_done");
        applyStimulus(4'b0, 16'h0, 8'd0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
